branch_update_ctrl: RTL and testbench
=====================================

Name: branch_update_ctrl

Overview:
- Sequences resolved-branch updates from the execute stage into the 32-entry branch predictor/target table's single write port, buffered in a small FIFO so table-port holds do not drop updates.
- Detects mispredictions, issues a pipeline flush plus redirect PC, and squashes wrong-path updates during recovery.
- Keeps saturating branch and mispredict statistics counters.
- Sits between the execute stage, the fetch redirect mux and the branch table.

Parameters:
- DEPTH, 4, update FIFO entries (power of 2, at least 2).
- FLUSH_CYCLES, 3, cycles flush stays high per mispredict (at least 1).
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- ex_valid  in  1  a resolved branch is presented this cycle.
- ex_pc  in  32  PC of the resolved branch.
- ex_taken  in  1  actual outcome.
- ex_target  in  32  actual taken target.
- ex_pred_taken  in  1  prediction carried down the pipe.
- ex_pred_target  in  32  predicted target carried down the pipe.
- ex_stall  out  1  FIFO full; execute must hold its branch.
- bt_hold  in  1  table write port unavailable this cycle.
- bt_write  out  1  write strobe to the table.
- bt_pc_write  out  32  PC index for the write.
- bt_branch_result  out  1  outcome to train the counter.
- bt_branch_address  out  32  target to store.
- flush  out  1  squash fetch/decode.
- redirect_valid  out  1  one-cycle pulse, redirect_pc valid.
- redirect_pc  out  32  correct next PC.
- branch_count  out  CNT_W  accepted branches, saturating.
- mispredict_count  out  CNT_W  mispredictions, saturating.

Behaviour:
- Reset (reset=0 at a clock edge):
  - FIFO is emptied; state goes to IDLE.
  - All outputs are 0: ex_stall, bt_write, flush, redirect_valid, both counters and all buses.
  - Reset mid-recovery or with the FIFO non-empty discards everything.
- Accept condition: ex_valid and not ex_stall and state equals IDLE.
  - An ex_valid arriving in RECOVER is a wrong-path branch. It is dropped and not counted, and ex_stall is not asserted for it.
- FIFO push on accept stores {ex_pc, ex_taken, ex_target}.
- Stall: ex_stall = (count == DEPTH). This is a registered count, with no same-cycle pop bypass.
- Pop happens when the FIFO is not empty and bt_hold=0.
  - bt_write=1 combinationally in that cycle, with bt_* driven from the FIFO head.
  - Pop is independent of the FSM state, so queued correct-path updates drain during RECOVER.
  - If not popping, bt_write=0 and the bt_* buses hold the head value (don't-care).
- Simultaneous push and pop while full is not possible because ex_stall gates the push. When not full, push and pop in the same cycle leave the count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Misprediction on accept is mis = (ex_taken != ex_pred_taken) or (ex_taken and ex_target != ex_pred_target).
- FSM has two states:
  - IDLE, on an accepted branch with mis=1:
    - go to RECOVER next cycle;
    - register redirect_pc = ex_taken ? ex_target : ex_pc+4 (32-bit wrap);
    - load the flush counter with FLUSH_CYCLES-1.
  - RECOVER:
    - flush=1;
    - redirect_valid=1 in the first RECOVER cycle only;
    - the counter decrements each cycle, and the state returns to IDLE after the cycle in which the counter is 0.
    - Total flush high time is FLUSH_CYCLES cycles.
- Latency: accept at edge N gives flush and redirect_valid high from N+1. The earliest bt_write for that branch is cycle N+1.
- The mispredicted branch's own update is still pushed, so the table is trained.
- Counters, on accept:
  - branch_count increments;
  - mispredict_count increments if mis;
  - both saturate at all-ones, with no wrap.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_IDLE, ST_RECOVER);
  - the FIFO entry struct {pc, taken, target} with width constant BU_ENTRY_W = 65;
  - PC_INC = 4.
- One natural sub-module, sync_fifo (parameterised width/depth, with count, full and empty outputs). The controller instantiates it once. FSM, mispredict compare and counters stay in the top level.

Test Plan:
- Reset then a correct prediction: ex_pc=0x40, taken=1, target=0x80, pred_taken=1, pred_target=0x80.
  - Expect bt_write next cycle with pc=0x40, result=1, address=0x80.
  - Expect flush=0 throughout, branch_count=1, mispredict_count=0.
- Direction mispredict: pc=0x100, taken=0, pred_taken=1.
  - Expect redirect_valid one cycle with redirect_pc=0x104.
  - Expect flush high for exactly 3 cycles and mispredict_count=1.
  - ex_valid asserted during those 3 cycles is not written to the table and not counted.
- Target mispredict: taken=1, target=0x200, pred_taken=1, pred_target=0x300.
  - Expect redirect_pc=0x200 and mispredict_count incremented.
- Hold with bt_hold=1 and 5 back-to-back correct branches:
  - ex_stall rises after the 4th accept; the 5th is held.
  - Releasing bt_hold drains entries in order, one per cycle, and then the 5th is accepted.
- Reset mid-operation: FIFO with 3 entries while in RECOVER, then reset=0 for one cycle.
  - Expect next cycle bt_write=0, flush=0, counters=0, ex_stall=0.
  - No stale write appears afterwards.
- Saturation with CNT_W=4: 17 accepted mispredicts.
  - Expect both counters to stop at 15.

Source files
------------

// File: rtl/branch_update_ctrl_pkg.sv
// branch_update_ctrl_pkg: shared FSM encoding, FIFO entry layout and PC increment
package branch_update_ctrl_pkg;
    typedef enum logic {ST_IDLE, ST_RECOVER} bu_state_t;
    localparam int BU_ENTRY_W = 65;
    localparam logic [31:0] PC_INC = 32'd4;
    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } bu_entry_t;
endpackage

// File: rtl/branch_update_ctrl_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/branch_update_ctrl.sv
// branch_update_ctrl: buffers resolved-branch table updates, flushes and redirects on mispredict
module branch_update_ctrl
    import branch_update_ctrl_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             ex_stall,
    input  logic             bt_hold,
    output logic             bt_write,
    output logic [31:0]      bt_pc_write,
    output logic             bt_branch_result,
    output logic [31:0]      bt_branch_address,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    bu_state_t     state_q, state_d;
    logic [FW-1:0] cnt_q, cnt_d;
    bu_entry_t     push_entry, head;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    logic          accept, mis, pop;
    assign accept     = ex_valid && !fifo_full && state_q == ST_IDLE;
    assign mis        = (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
    assign pop        = !fifo_empty && !bt_hold;
    assign push_entry = '{pc: ex_pc, taken: ex_taken, target: ex_target};
    assign ex_stall   = fifo_count == CW'(DEPTH);
    sync_fifo #(.W(BU_ENTRY_W), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    // Buses read zero while empty so stale memory never shows after reset
    assign bt_write          = pop;
    assign bt_pc_write       = fifo_empty ? '0 : head.pc;
    assign bt_branch_result  = fifo_empty ? 1'b0 : head.taken;
    assign bt_branch_address = fifo_empty ? '0 : head.target;
    assign flush             = state_q == ST_RECOVER;
    assign redirect_valid    = flush && cnt_q == FW'(FLUSH_CYCLES - 1);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_IDLE) begin
            if (accept && mis) begin
                state_d = ST_RECOVER;
                cnt_d   = FW'(FLUSH_CYCLES - 1);
            end
        end else begin
            cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
            state_d = cnt_q == '0 ? ST_IDLE : ST_RECOVER;
        end
    end
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept && mis) redirect_pc <= ex_taken ? ex_target : ex_pc + PC_INC;
            if (accept && !(&branch_count)) branch_count <= branch_count + 1'b1;
            if (accept && mis && !(&mispredict_count)) mispredict_count <= mispredict_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_update_ctrl.sv
// tb_branch_update_ctrl: directed self-checking bench for branch_update_ctrl
module tb_branch_update_ctrl;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        ex_stall;
    logic        bt_hold = 1'b0;
    logic        bt_write;
    logic [31:0] bt_pc_write;
    logic        bt_branch_result;
    logic [31:0] bt_branch_address;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [3:0]  branch_count;
    logic [3:0]  mispredict_count;
    int checks = 0;
    int errors = 0;

    branch_update_ctrl #(.DEPTH(4), .FLUSH_CYCLES(3), .CNT_W(4)) dut (
        .clock             (clock),
        .reset             (reset),
        .ex_valid          (ex_valid),
        .ex_pc             (ex_pc),
        .ex_taken          (ex_taken),
        .ex_target         (ex_target),
        .ex_pred_taken     (ex_pred_taken),
        .ex_pred_target    (ex_pred_target),
        .ex_stall          (ex_stall),
        .bt_hold           (bt_hold),
        .bt_write          (bt_write),
        .bt_pc_write       (bt_pc_write),
        .bt_branch_result  (bt_branch_result),
        .bt_branch_address (bt_branch_address),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                         input logic ptk, input logic [31:0] ptg);
        ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tg;
        ex_pred_taken = ptk; ex_pred_target = ptg;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        tick; tick;
        #1;
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0h want 0", ex_stall); end
        checks++; if (bt_write !== 1'b0) begin errors++; $display("FAIL rst_write got %0h want 0", bt_write); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %0h want 0", flush); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_rv got %0h want 0", redirect_valid); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_rpc got %0h want 0", redirect_pc); end
        checks++; if (bt_pc_write !== 32'h0 || bt_branch_address !== 32'h0 || bt_branch_result !== 1'b0) begin
            errors++; $display("FAIL rst_bus got %0h/%0h/%0h want 0", bt_pc_write, bt_branch_address, bt_branch_result); end
        checks++; if (branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
            errors++; $display("FAIL rst_cnt got %0d/%0d want 0/0", branch_count, mispredict_count); end
        reset = 1'b1;
    endtask

    task automatic test_correct;
        drive(32'h40, 1'b1, 32'h80, 1'b1, 32'h80);
        #1;
        checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL ok_stall got %0h want 0", ex_stall); end
        tick;
        ex_valid = 1'b0;
        #1;
        checks++; if (bt_write !== 1'b1 || bt_pc_write !== 32'h40 || bt_branch_result !== 1'b1 || bt_branch_address !== 32'h80) begin
            errors++; $display("FAIL ok_write got %0h pc=%0h r=%0h a=%0h want 1 40 1 80", bt_write, bt_pc_write, bt_branch_result, bt_branch_address); end
        checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) begin errors++; $display("FAIL ok_flush got %0h/%0h want 0/0", flush, redirect_valid); end
        checks++; if (branch_count !== 4'd1 || mispredict_count !== 4'd0) begin
            errors++; $display("FAIL ok_cnt got %0d/%0d want 1/0", branch_count, mispredict_count); end
        tick;
        #1;
        checks++; if (bt_write !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL ok_idle got %0h/%0h want 0/0", bt_write, flush); end
    endtask

    task automatic test_dir_mispredict;
        drive(32'h100, 1'b0, 32'h0, 1'b1, 32'h0);
        tick;
        drive(32'h500, 1'b1, 32'h540, 1'b1, 32'h540);
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin
            errors++; $display("FAIL dir_redirect got %0h pc=%0h want 1 104", redirect_valid, redirect_pc); end
        checks++; if (bt_write !== 1'b1 || bt_pc_write !== 32'h100 || bt_branch_result !== 1'b0) begin
            errors++; $display("FAIL dir_write got %0h pc=%0h r=%0h want 1 100 0", bt_write, bt_pc_write, bt_branch_result); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (flush !== 1'b1) begin errors++; $display("FAIL dir_flush%0d got %0h want 1", c, flush); end
            checks++; if (c > 0 && (redirect_valid !== 1'b0 || bt_write !== 1'b0)) begin
                errors++; $display("FAIL dir_recover%0d got rv=%0h wr=%0h want 0 0", c, redirect_valid, bt_write); end
            checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL dir_stall%0d got %0h want 0", c, ex_stall); end
            tick;
            if (c == 2) ex_valid = 1'b0;
            #1;
        end
        checks++; if (flush !== 1'b0 || bt_write !== 1'b0) begin errors++; $display("FAIL dir_end got %0h/%0h want 0/0", flush, bt_write); end
        checks++; if (branch_count !== 4'd2 || mispredict_count !== 4'd1) begin
            errors++; $display("FAIL dir_cnt got %0d/%0d want 2/1", branch_count, mispredict_count); end
    endtask

    task automatic test_target_mispredict;
        drive(32'h180, 1'b1, 32'h200, 1'b1, 32'h300);
        tick;
        ex_valid = 1'b0;
        #1;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin
            errors++; $display("FAIL tgt_redirect got %0h pc=%0h want 1 200", redirect_valid, redirect_pc); end
        checks++; if (bt_write !== 1'b1 || bt_pc_write !== 32'h180 || bt_branch_address !== 32'h200) begin
            errors++; $display("FAIL tgt_write got %0h pc=%0h a=%0h want 1 180 200", bt_write, bt_pc_write, bt_branch_address); end
        checks++; if (branch_count !== 4'd3 || mispredict_count !== 4'd2) begin
            errors++; $display("FAIL tgt_cnt got %0d/%0d want 3/2", branch_count, mispredict_count); end
        tick; tick; tick;
        #1;
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL tgt_end got %0h want 0", flush); end
    endtask

    task automatic test_back_to_back_hold;
        logic [31:0] pc;
        bt_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc = 32'h1000 + 32'(i * 16);
            drive(pc, 1'b1, pc + 32'h40, 1'b1, pc + 32'h40);
            #1;
            checks++; if (ex_stall !== (i == 4)) begin errors++; $display("FAIL hold_stall%0d got %0h want %0h", i, ex_stall, i == 4); end
            checks++; if (bt_write !== 1'b0) begin errors++; $display("FAIL hold_write%0d got %0h want 0", i, bt_write); end
            if (i < 4) tick;
        end
        bt_hold = 1'b0;
        for (int j = 0; j < 5; j++) begin
            #1;
            checks++; if (bt_write !== 1'b1 || bt_pc_write !== 32'h1000 + 32'(j * 16) || bt_branch_address !== 32'h1040 + 32'(j * 16)) begin
                errors++; $display("FAIL drain%0d got %0h pc=%0h a=%0h want 1 %0h %0h", j, bt_write, bt_pc_write, bt_branch_address,
                                   32'h1000 + 32'(j * 16), 32'h1040 + 32'(j * 16)); end
            checks++; if (j < 2 && ex_stall !== (j == 0)) begin errors++; $display("FAIL drain_stall%0d got %0h want %0h", j, ex_stall, j == 0); end
            tick;
            if (j == 1) ex_valid = 1'b0;
        end
        #1;
        checks++; if (bt_write !== 1'b0 || ex_stall !== 1'b0) begin errors++; $display("FAIL drain_end got %0h/%0h want 0/0", bt_write, ex_stall); end
        checks++; if (branch_count !== 4'd8 || mispredict_count !== 4'd2) begin
            errors++; $display("FAIL drain_cnt got %0d/%0d want 8/2", branch_count, mispredict_count); end
    endtask

    task automatic test_reset_mid;
        bt_hold = 1'b1;
        drive(32'h2000, 1'b1, 32'h2100, 1'b1, 32'h2100);
        tick;
        drive(32'h2010, 1'b0, 32'h0, 1'b0, 32'h0);
        tick;
        drive(32'h2020, 1'b0, 32'h0, 1'b1, 32'h0);
        tick;
        ex_valid = 1'b0;
        #1;
        checks++; if (flush !== 1'b1 || ex_stall !== 1'b0) begin errors++; $display("FAIL mid_pre got %0h/%0h want 1/0", flush, ex_stall); end
        reset = 1'b0;
        tick;
        reset = 1'b1;
        bt_hold = 1'b0;
        #1;
        checks++; if (bt_write !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0 || ex_stall !== 1'b0) begin
            errors++; $display("FAIL mid_out got wr=%0h fl=%0h rv=%0h st=%0h want 0", bt_write, flush, redirect_valid, ex_stall); end
        checks++; if (branch_count !== 4'd0 || mispredict_count !== 4'd0) begin
            errors++; $display("FAIL mid_cnt got %0d/%0d want 0/0", branch_count, mispredict_count); end
        for (int c = 0; c < 4; c++) begin
            tick;
            #1;
            checks++; if (bt_write !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got %0h/%0h want 0/0", c, bt_write, flush); end
        end
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 17; i++) begin
            drive(32'h3000 + 32'(i * 8), 1'b0, 32'h0, 1'b1, 32'h0);
            tick;
            ex_valid = 1'b0;
            tick; tick; tick;
            if (i == 13) begin
                #1;
                checks++; if (branch_count !== 4'd14 || mispredict_count !== 4'd14) begin
                    errors++; $display("FAIL sat_mid got %0d/%0d want 14/14", branch_count, mispredict_count); end
            end
        end
        #1;
        checks++; if (branch_count !== 4'd15 || mispredict_count !== 4'd15) begin
            errors++; $display("FAIL sat_end got %0d/%0d want 15/15", branch_count, mispredict_count); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL sat_flush got %0h want 0", flush); end
    endtask

    initial begin
        test_reset;
        test_correct;
        test_dir_mispredict;
        test_target_mispredict;
        test_back_to_back_hold;
        test_reset_mid;
        test_saturation;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
